// File: rtl/regfile_pkg.sv
// Shared widths and types for the general-purpose register file.
package regfile_pkg;
   localparam int REG_DATA_W = 32;
   localparam int REG_ADDR_W = 4;
   localparam int REG_COUNT  = 16;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file.
// With REGFILE_BYPASS_EN defined, a same-address write in flight is forwarded.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic [DEPTH-1:0][DATA_W-1:0] mem,
   input  logic [ADDR_W-1:0]            ra,
`ifdef REGFILE_BYPASS_EN
   input  logic                         rst_n,
   input  logic                         we,
   input  logic [ADDR_W-1:0]            wa,
   input  logic [DATA_W-1:0]            wd,
`endif
   output logic [DATA_W-1:0]            rd
);

`ifdef REGFILE_BYPASS_EN
   // Reset gates forwarding so outputs read zero while the array is cleared.
   always_comb begin
      rd = mem[ra];
      if (rst_n && we && (wa == ra)) rd = wd;
   end
`else
   always_comb begin
      rd = mem[ra];
   end
`endif

endmodule

// File: rtl/register_file.sv
// 16 x 32 register file: two async read ports, one sync write port.
// Optional write-through forwarding with REGFILE_BYPASS_EN.
module register_file
   import regfile_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we3,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   input  logic [ADDR_W-1:0] wa3,
   input  logic [DATA_W-1:0] wd3,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int NPORT = 2;

   logic [DEPTH-1:0][DATA_W-1:0] mem;
   logic [DEPTH-1:0]             wsel;
   logic [NPORT-1:0][ADDR_W-1:0] ra_v;
   logic [NPORT-1:0][DATA_W-1:0] rd_v;

   always_comb begin
      wsel = '0;
      for (int i = 0; i < DEPTH; i++)
         wsel[i] = we3 && (wa3 == ADDR_W'(i));
   end

   // Entry 0 is ordinary storage; nothing is hardwired.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (wsel[i]) mem[i] <= wd3;
      end
   end

   assign ra_v = {ra2, ra1};

   for (genvar p = 0; p < NPORT; p++) begin : g_rp
      regfile_read_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .DEPTH  (DEPTH)
      ) u_rp (
         .mem   (mem),
         .ra    (ra_v[p]),
`ifdef REGFILE_BYPASS_EN
         .rst_n (rst_n),
         .we    (we3),
         .wa    (wa3),
         .wd    (wd3),
`endif
         .rd    (rd_v[p])
      );
   end

   assign rd1 = rd_v[0];
   assign rd2 = rd_v[1];

endmodule

// File: tb/tb_register_file.sv
// Directed vector bench for register_file, default or REGFILE_BYPASS_EN build.
module tb_register_file;

   logic        clk, rst_n, we3;
   logic [3:0]  ra1, ra2, wa3;
   logic [31:0] wd3, rd1, rd2;

   int total = 0;
   int bad   = 0;

   register_file dut (
      .clk(clk), .rst_n(rst_n), .we3(we3),
      .ra1(ra1), .ra2(ra2), .wa3(wa3), .wd3(wd3),
      .rd1(rd1), .rd2(rd2)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   typedef struct {
      logic        we;
      logic [3:0]  wa;
      logic [31:0] wd;
      logic [3:0]  ra1;
      logic [3:0]  ra2;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   vec_t vt [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive on the falling edge, compare just after the following rising edge.
   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      we3 = v.we; wa3 = v.wa; wd3 = v.wd; ra1 = v.ra1; ra2 = v.ra2;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_rd1", idx), rd1, v.e1);
      chk($sformatf("vec%0d_rd2", idx), rd2, v.e2);
   endtask

   initial begin
      logic [31:0] exp_rdw;

      vt[0] = '{1'b1, 4'd0, 32'd10,         4'd0, 4'd5, 32'd10,         32'd0};
      vt[1] = '{1'b1, 4'd3, 32'hDEADBEEF,   4'd0, 4'd3, 32'd10,         32'hDEADBEEF};
      vt[2] = '{1'b0, 4'd3, 32'h12345678,   4'd3, 4'd3, 32'hDEADBEEF,   32'hDEADBEEF};
      vt[3] = '{1'b1, 4'd15, 32'h0000_00FF, 4'd15, 4'd0, 32'h0000_00FF, 32'd10};
      vt[4] = '{1'b1, 4'd0, 32'hFFFF_FFFF,  4'd0, 4'd15, 32'hFFFF_FFFF, 32'h0000_00FF};
      vt[5] = '{1'b0, 4'd0, 32'd0,          4'd5, 4'd3, 32'd0,          32'hDEADBEEF};

      // Reset asserted before any clock edge: reads are zero immediately.
      rst_n = 1'b0; we3 = 1'b0; wa3 = '0; wd3 = '0; ra1 = 4'd5; ra2 = 4'd15;
      #2;
      chk("reset_rd1", rd1, 32'd0);
      chk("reset_rd2", rd2, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) apply(vt[i], i);

      // Sweep: every entry holds its own tag.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         we3 = 1'b1; wa3 = 4'(i); wd3 = 32'hA5A50000 + 32'(i);
      end
      @(negedge clk);
      we3 = 1'b0;
      for (int i = 0; i < 16; i++) begin
         ra1 = 4'(i); ra2 = 4'(15 - i);
         #1;
         chk($sformatf("sweep_rd1_%0d", i), rd1, 32'hA5A50000 + 32'(i));
         chk($sformatf("sweep_rd2_%0d", 15 - i), rd2, 32'hA5A50000 + 32'(15 - i));
      end
      ra1 = 4'd7; ra2 = 4'd7;
      #1;
      chk("same_addr_rd1", rd1, 32'hA5A50007);
      chk("same_addr_rd2", rd2, 32'hA5A50007);

      // Read-during-write on entry 4.
      @(negedge clk);
      we3 = 1'b1; wa3 = 4'd4; wd3 = 32'd1;
      @(negedge clk);
      we3 = 1'b1; wa3 = 4'd4; wd3 = 32'd2; ra1 = 4'd4; ra2 = 4'd5;
      #1;
`ifdef REGFILE_BYPASS_EN
      exp_rdw = 32'd2;
`else
      exp_rdw = 32'd1;
`endif
      chk("rdw_before_edge", rd1, exp_rdw);
      chk("rdw_other_port", rd2, 32'hA5A50005);
      @(posedge clk);
      #1;
      chk("rdw_after_edge", rd1, 32'd2);
      @(negedge clk);
      we3 = 1'b0;

      // Async reset between edges with the array full of nonzero data.
      #2;
      rst_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ra1 = 4'(2 * i); ra2 = 4'(2 * i + 1);
         #1;
         chk($sformatf("arst_rd1_%0d", 2 * i), rd1, 32'd0);
         chk($sformatf("arst_rd2_%0d", 2 * i + 1), rd2, 32'd0);
      end
      // Write attempted on an edge while reset is held; no forwarding either.
      we3 = 1'b1; wa3 = 4'd9; wd3 = 32'h0000FFFF; ra1 = 4'd9; ra2 = 4'd9;
      #1;
      chk("arst_no_fwd", rd1, 32'd0);
      @(posedge clk);
      #1;
      chk("arst_write_ignored", rd2, 32'd0);
      @(negedge clk);
      we3 = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
      chk("post_rst_rd1", rd1, 32'd0);
      chk("post_rst_rd2", rd2, 32'd0);

      // First write after release lands on the next rising edge.
      @(negedge clk);
      we3 = 1'b1; wa3 = 4'd9; wd3 = 32'h0BADF00D;
      @(posedge clk);
      #1;
      chk("post_rst_write", rd1, 32'h0BADF00D);
      @(negedge clk);
      we3 = 1'b0;
      ra2 = 4'd8;
      #1;
      chk("post_rst_isolation", rd2, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
